// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART receiver: hunts for SOF, parses a length-prefixed frame, streams the payload.
// Optional trailer checksum enabled by defining FRAME_CSUM_EN.
module uart_rx_frame_ctrl #(
    parameter int          DW          = 8,
    parameter logic [DW-1:0] SOF       = 8'hA5,
    parameter int          MAX_LEN     = 64,
    parameter int          TIMEOUT_CYC = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_data_ready,
    input  logic [DW-1:0] rx_par,
    output logic          rx_akn,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          frame_done,
    output logic          frame_err,
    output logic [1:0]    err_code
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CSUM} state_t;

    state_t        state, state_n;
    logic [CW-1:0] len_reg, len_n;
    logic [CW-1:0] pay_cnt, cnt_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic [DW-1:0] data_n;
    logic          valid_n, last_n, done_n, err_n;
    logic [1:0]    code_n;
    logic          can_take, acc;
`ifdef FRAME_CSUM_EN
    logic [DW-1:0] sum, sum_n;
`endif

    // PAYLOAD only takes a word when the output register is free or draining this cycle
    assign can_take = (state != PAYLOAD) || !out_valid || out_ready;
    assign acc      = rx_data_ready && !rx_akn && can_take;

    always_comb begin
        state_n = state;
        len_n   = len_reg;
        cnt_n   = pay_cnt;
        tmo_n   = tmo_cnt;
        data_n  = out_data;
        valid_n = out_valid;
        last_n  = out_last;
        done_n  = 1'b0;
        err_n   = 1'b0;
        code_n  = 2'd0;
`ifdef FRAME_CSUM_EN
        sum_n   = sum;
`endif
        if (out_valid && out_ready) begin
            valid_n = 1'b0;
            last_n  = 1'b0;
        end

        case (state)
            HUNT: begin
                if (acc && rx_par == SOF)
                    state_n = LEN;
            end
            LEN: begin
                if (acc) begin
                    if (int'(rx_par) > MAX_LEN) begin
                        err_n   = 1'b1;
                        code_n  = 2'd3;
                        state_n = HUNT;
                    end else begin
                        len_n = CW'(rx_par);
                        cnt_n = '0;
`ifdef FRAME_CSUM_EN
                        sum_n = rx_par;
                        state_n = (rx_par == '0) ? CSUM : PAYLOAD;
`else
                        if (rx_par == '0) begin
                            done_n  = 1'b1;
                            state_n = HUNT;
                        end else begin
                            state_n = PAYLOAD;
                        end
`endif
                    end
                end
            end
            PAYLOAD: begin
                if (acc) begin
                    data_n  = rx_par;
                    valid_n = 1'b1;
                    cnt_n   = pay_cnt + 1'b1;
`ifdef FRAME_CSUM_EN
                    sum_n   = sum + rx_par;
`endif
                    if (pay_cnt == len_reg - CW'(1)) begin
                        last_n = 1'b1;
`ifdef FRAME_CSUM_EN
                        state_n = CSUM;
`else
                        done_n  = 1'b1;
                        state_n = HUNT;
`endif
                    end else begin
                        last_n = 1'b0;
                    end
                end
            end
            CSUM: begin
`ifdef FRAME_CSUM_EN
                if (acc) begin
                    if (DW'(sum + rx_par) == '0) begin
                        done_n = 1'b1;
                    end else begin
                        err_n  = 1'b1;
                        code_n = 2'd1;
                    end
                    state_n = HUNT;
                end
`else
                state_n = HUNT;
`endif
            end
            default: state_n = HUNT;
        endcase

        // inter-byte watchdog; an accepted word in the same cycle always wins
        if (state == HUNT) begin
            tmo_n = '0;
        end else if (acc) begin
            tmo_n = '0;
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            tmo_n   = '0;
            err_n   = 1'b1;
            code_n  = 2'd2;
            state_n = HUNT;
        end else begin
            tmo_n = tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            rx_akn     <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'd0;
            len_reg    <= '0;
            pay_cnt    <= '0;
            tmo_cnt    <= '0;
`ifdef FRAME_CSUM_EN
            sum        <= '0;
`endif
        end else begin
            state      <= state_n;
            rx_akn     <= acc;
            out_valid  <= valid_n;
            out_last   <= last_n;
            out_data   <= data_n;
            frame_done <= done_n;
            frame_err  <= err_n;
            err_code   <= code_n;
            len_reg    <= len_n;
            pay_cnt    <= cnt_n;
            tmo_cnt    <= tmo_n;
`ifdef FRAME_CSUM_EN
            sum        <= sum_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl (MAX_LEN=64, TIMEOUT_CYC=100); expectations follow FRAME_CSUM_EN.
module tb_uart_rx_frame_ctrl;

`ifdef FRAME_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_data_ready = 1'b0;
    logic [7:0] rx_par = 8'h00;
    logic       rx_akn;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;

    uart_rx_frame_ctrl #(.DW(8), .SOF(8'hA5), .MAX_LEN(64), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .rx_data_ready(rx_data_ready), .rx_par(rx_par),
        .rx_akn(rx_akn), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .frame_done(frame_done),
        .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // monitor, sampled on the falling edge
    int         cyc = 0, akn_cnt = 0, done_cnt = 0, err_cnt = 0, valid_cnt = 0;
    int         last_akn_cyc = 0, err_cyc = 0, both_cnt = 0, done_noakn = 0;
    logic [1:0] last_code = 2'd0;
    logic [8:0] words[$];

    always @(negedge clk) begin
        cyc++;
        if (rx_akn) begin akn_cnt++; last_akn_cyc = cyc; end
        if (frame_done) done_cnt++;
        if (frame_done && !rx_akn) done_noakn++;
        if (frame_err) begin err_cnt++; err_cyc = cyc; last_code = err_code; end
        if (frame_done && frame_err) both_cnt++;
        if (out_valid) valid_cnt++;
        if (!rst && out_valid && out_ready) words.push_back({out_last, out_data});
    end

    int a0, d0, e0, v0, q0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        a0 = akn_cnt; d0 = done_cnt; e0 = err_cnt; v0 = valid_cnt; q0 = words.size();
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        rx_par = b;
        rx_data_ready = 1'b1;
        n = 0;
        while (!rx_akn && n < 400) begin @(posedge clk); #1; n++; end
        if (!rx_akn) chk("akn_wait", 32'(rx_akn), 32'd1);
        rx_data_ready = 1'b0;
        tick(1);
    endtask

    task automatic word_at(input string tag, input int idx, input logic [8:0] exp);
        if (q0 + idx < words.size()) chk(tag, 32'(words[q0 + idx]), 32'(exp));
        else chk(tag, 32'hDEAD, 32'(exp));
    endtask

    initial begin
        tick(3);
        // reset values
        chk("rst_akn", 32'(rx_akn), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_code", 32'(err_code), 0);
        rst = 1'b0;
        tick(2);

        // clean frame
        snap();
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'hCE);
        tick(3);
        chk("clean_akn", 32'(akn_cnt - a0), 5);
        chk("clean_nwords", 32'(words.size() - q0), 2);
        word_at("clean_w0", 0, 9'h010);
        word_at("clean_w1", 1, 9'h120);
        chk("clean_done", 32'(done_cnt - d0), 1);
        chk("clean_err", 32'(err_cnt - e0), 0);

        // bad checksum
        snap();
        send(8'hA5); send(8'h01); send(8'h55); send(8'h00);
        tick(3);
        word_at("badcs_w0", 0, 9'h155);
        chk("badcs_err", 32'(err_cnt - e0), CSUM ? 1 : 0);
        chk("badcs_done", 32'(done_cnt - d0), CSUM ? 0 : 1);
        if (CSUM) chk("badcs_code", 32'(last_code), 1);

        // leading garbage then oversize length
        snap();
        send(8'h00); send(8'h7F); send(8'hA5); send(8'h41);
        tick(3);
        chk("big_akn", 32'(akn_cnt - a0), 4);
        chk("big_err", 32'(err_cnt - e0), 1);
        chk("big_code", 32'(last_code), 3);
        chk("big_valid", 32'(valid_cnt - v0), 0);
        chk("big_done", 32'(done_cnt - d0), 0);

        // zero-length frame
        snap();
        send(8'hA5); send(8'h00); send(8'h00);
        tick(3);
        chk("len0_done", 32'(done_cnt - d0), 1);
        chk("len0_words", 32'(words.size() - q0), 0);
        chk("len0_err", 32'(err_cnt - e0), 0);

        // backpressure
        snap();
        out_ready = 1'b0;
        send(8'hA5); send(8'h03); send(8'h01);
        rx_par = 8'h02;
        rx_data_ready = 1'b1;
        tick(50);
        chk("bp_akn_held", 32'(akn_cnt - a0), 3);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_data", 32'(out_data), 32'h01);
        chk("bp_last", 32'(out_last), 0);
        out_ready = 1'b1;
        send(8'h02); send(8'h03); send(8'hF7);
        tick(3);
        chk("bp_nwords", 32'(words.size() - q0), 3);
        word_at("bp_w0", 0, 9'h001);
        word_at("bp_w1", 1, 9'h002);
        word_at("bp_w2", 2, 9'h103);
        chk("bp_done", 32'(done_cnt - d0), 1);

        // inter-byte timeout
        snap();
        send(8'hA5); send(8'h02); send(8'h11);
        begin
            int n;
            n = 0;
            while (err_cnt == e0 && n < 300) begin tick(1); n++; end
        end
        tick(2);
        chk("tmo_err", 32'(err_cnt - e0), 1);
        chk("tmo_code", 32'(last_code), 2);
        chk("tmo_delay", 32'(err_cyc - last_akn_cyc), 100);
        word_at("tmo_w0", 0, 9'h011);
        snap();
        send(8'hA5); send(8'h01); send(8'h7E); send(8'h81);
        tick(3);
        chk("post_tmo_done", 32'(done_cnt - d0), 1);
        word_at("post_tmo_w0", 0, 9'h17E);

        // maximum-length frame
        snap();
        send(8'hA5); send(8'h40);
        for (int i = 0; i < 64; i++) send(8'(i));
        send(8'hE0);
        tick(3);
        chk("max_nwords", 32'(words.size() - q0), 64);
        word_at("max_w63", 63, 9'h13F);
        chk("max_done", 32'(done_cnt - d0), 1);
        chk("max_err", 32'(err_cnt - e0), 0);

        // reset while a payload word is pending
        out_ready = 1'b0;
        send(8'hA5); send(8'h02); send(8'h33);
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_last", 32'(out_last), 0);
        chk("mid_rst_akn", 32'(rx_akn), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick(1);
        snap();
        send(8'hA5); send(8'h01); send(8'h44); send(8'hBB);
        tick(3);
        chk("post_rst_nwords", 32'(words.size() - q0), 1);
        word_at("post_rst_w0", 0, 9'h144);
        chk("post_rst_done", 32'(done_cnt - d0), 1);

        chk("never_both", 32'(both_cnt), 0);
        chk("done_with_akn", 32'(done_noakn), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Frame-level controller sitting directly behind the UART receiver. It owns the receiver's ready/acknowledge handshake and hunts for a start-of-frame byte. It parses a length-prefixed frame, streams payload bytes out through a valid/ready port and reports frame completion or error. It converts the raw byte stream into framed packets for downstream command logic.

## Interface
- DW, 8: data width of received words and payload.
- SOF, 8'hA5: start-of-frame value.
- MAX_LEN, 64: largest accepted payload length.
- TIMEOUT_CYC, 100000: maximum clk cycles between accepted bytes inside a frame.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rx_data_ready  in  1  receiver holds a valid word.
- rx_par  in  DW  received word.
- rx_akn  out  1  registered one-cycle acknowledge to the receiver.
- out_valid  out  1  payload word valid.
- out_ready  in  1  downstream accepts the payload word.
- out_data  out  DW  payload word.
- out_last  out  1  marks the final payload word of a frame.
- frame_done  out  1  one-cycle pulse: frame received correctly.
- frame_err  out  1  one-cycle pulse: frame aborted.
- err_code  out  2  cause, valid only with frame_err: 1 = checksum, 2 = timeout, 3 = length > MAX_LEN.

## Operation
- States:
  - HUNT: wait for SOF.
  - LEN: take the length byte.
  - PAYLOAD: stream LEN words.
  - CSUM: check the trailer.
- Accept condition: rx_data_ready=1, rx_akn=0, and the state can take a word.
  - PAYLOAD can take a word only when out_valid=0, or when out_valid&out_ready=1 in the same cycle.
  - Other states always can.
- Accepted word: rx_akn=1 on the next cycle. While rx_akn=1, rx_data_ready is ignored, because the receiver drops it one cycle after the acknowledge.
- HUNT:
  - SOF → LEN.
  - Any other value is acknowledged and discarded.
- LEN:
  - Stores len and initialises sum = len (mod 2^DW).
  - len > MAX_LEN → frame_err with code 3, return to HUNT.
  - len = 0 → CSUM.
  - Otherwise → PAYLOAD.
- PAYLOAD:
  - Each accepted word is loaded into out_data and out_valid is set; sum += word.
  - out_last=1 on the len-th word, after which the state → CSUM.
  - out_valid clears on out_valid&out_ready unless a new word loads in the same cycle.
- CSUM:
  - (sum + word) mod 2^DW = 0 → frame_done.
  - Otherwise → frame_err with code 1.
  - Either way → HUNT.
- Timeout:
  - Counter is active in LEN, PAYLOAD and CSUM, and clears on every accepted word.
  - Reaching TIMEOUT_CYC-1 → frame_err with code 2, return to HUNT.
  - A word accepted in the same cycle wins: the counter clears and no timeout is raised.
- A payload word already in the output register is still delivered after a checksum error or timeout; downstream discards it on frame_err.
- Counter widths: $clog2(TIMEOUT_CYC+1) for the timeout counter; $clog2(MAX_LEN+1) for the payload counter.

## Timing
- Reset values:
  - State HUNT.
  - rx_akn, out_valid, out_last, frame_done, frame_err = 0.
  - out_data = 0, err_code = 0.
  - Counters = 0, sum = 0.
- Reset mid-frame drops any pending output word.
- Word accepted at cycle t:
  - rx_akn, out_data/out_valid, and any state change all take effect at t+1.
  - frame_done/frame_err pulse at t+1.
- Minimum spacing between accepted words: 2 cycles.
- out_data and out_last stay stable while out_valid=1 and out_ready=0.
- frame_done and frame_err are never high together.

## Configuration
- FRAME_CSUM_EN:
  - Defined: CSUM state and checksum check are present, as described above.
  - Undefined: no trailer byte is expected. frame_done pulses with the acceptance of the len-th payload word, or with the LEN byte when len = 0. err_code 1 never occurs.

## Test plan
- Clean frame: A5, 02, 10, 20, CE with out_ready=1 → out_data 10 then 20 (out_last on 20), frame_done pulse, 5 rx_akn pulses.
- Bad checksum: A5, 01, 55, 00 → out_data 55 with out_last, frame_err with err_code=1, state HUNT.
- Leading garbage plus oversize: 00, 7F, A5, 41 (MAX_LEN=64) → 00 and 7F acknowledged and dropped, frame_err with err_code=3, no out_valid.
- Backpressure: A5, 03, 01, 02, 03 with out_ready=0 for 50 cycles → rx_akn withheld for the second payload word until the first is taken, data order preserved.
- Timeout: A5, 02, 11 then silence with TIMEOUT_CYC=100 → frame_err with err_code=2 exactly 100 cycles after the last acknowledge; a following valid frame is received correctly.
- Reset mid-PAYLOAD with out_valid=1 → all outputs at reset values next cycle; a following frame decodes correctly.
